// File: rtl/bw_decode_sequencer.sv
// Purpose : queues fetched instructions and presents decode groups of a base
//           instruction plus up to three postfixes; orphan postfixes are dropped.
// Latency : a group complete in cycle t is valid at t+1 (register EMPTY or consumed).
// Backpressure: in_ready_o drops when 8 entries are queued or during flush;
//           the output register holds while out_valid_o=1 and out_ready_i=0.
// Ports   : rst_i/clk_i, flush_i, drain_i, in_valid_i/in_ready_o/in_ir_i,
//           out_valid_o/out_ready_i/out_ir*_o/out_npfx_o, err_orphan_o, count_o.
module bw_decode_sequencer #(
    parameter int               IW      = 40,
    parameter int               OPW     = 7,
    parameter logic [OPW-1:0]   CON1_OP = 7'h0B,
    parameter logic [OPW-1:0]   CON2_OP = 7'h2B,
    parameter logic [OPW-1:0]   CON3_OP = 7'h5B,
    parameter logic [IW-1:0]    NOP_IR  = 40'h13,
    parameter int               DEPTH   = 8
) (
    input  logic            rst_i,
    input  logic            clk_i,
    input  logic            flush_i,
    input  logic            drain_i,
    input  logic            in_valid_i,
    input  logic [IW-1:0]   in_ir_i,
    output logic            in_ready_o,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [IW-1:0]   out_ir_o,
    output logic [IW-1:0]   out_ir1_o,
    output logic [IW-1:0]   out_ir2_o,
    output logic [IW-1:0]   out_ir3_o,
    output logic [1:0]      out_npfx_o,
    output logic            err_orphan_o,
    output logic [3:0]      count_o
);
    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;

    logic [IW-1:0] mem_q [0:DEPTH-1];
    logic [2:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [3:0]    count_q, count_d;
    logic          state_q, state_d;
    logic [IW-1:0] ir_q, ir_d, ir1_q, ir1_d, ir2_q, ir2_d, ir3_q, ir3_d;
    logic [1:0]    npfx_q, npfx_d;
    logic          err_q, err_d;

    function automatic logic is_pfx(input logic [IW-1:0] ir);
        return (ir[OPW-1:0] == CON1_OP) || (ir[OPW-1:0] == CON2_OP) ||
               (ir[OPW-1:0] == CON3_OP);
    endfunction

    // Head window: the four oldest registered entries.
    logic [2:0]    ra1, ra2, ra3;
    logic [IW-1:0] e0, e1, e2, e3;
    assign ra1 = rptr_q + 3'd1;
    assign ra2 = rptr_q + 3'd2;
    assign ra3 = rptr_q + 3'd3;
    assign e0  = mem_q[rptr_q];
    assign e1  = mem_q[ra1];
    assign e2  = mem_q[ra2];
    assign e3  = mem_q[ra3];

    // Postfix run after the head, only over entries actually queued.
    logic       head_vld, head_pfx, p1, p2, p3, complete, can_load, push;
    logic [1:0] n;
    logic [3:0] grp_len, pop_n;
    assign head_vld = (count_q != 4'd0);
    assign head_pfx = head_vld && is_pfx(e0);
    assign p1 = (count_q >= 4'd2) && is_pfx(e1);
    assign p2 = p1 && (count_q >= 4'd3) && is_pfx(e2);
    assign p3 = p2 && (count_q >= 4'd4) && is_pfx(e3);
    assign n  = p3 ? 2'd3 : (p2 ? 2'd2 : (p1 ? 2'd1 : 2'd0));
    assign grp_len = {2'b00, n} + 4'd1;
    // An entry beyond the run (count > L) can only be a non-postfix when n < 3.
    assign complete = head_vld && !head_pfx &&
                      ((n == 2'd3) || (count_q > grp_len) || drain_i);
    assign can_load = (state_q == ST_EMPTY) || out_ready_i;

    assign in_ready_o = (count_q < 4'(DEPTH)) && !flush_i;
    assign push       = in_valid_i && in_ready_o;

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        ir1_d   = ir1_q;
        ir2_d   = ir2_q;
        ir3_d   = ir3_q;
        npfx_d  = npfx_q;
        err_d   = 1'b0;
        pop_n   = 4'd0;
        if (flush_i) begin
            state_d = ST_EMPTY;
        end else if (can_load) begin
            if (head_pfx) begin
                pop_n   = 4'd1;
                err_d   = 1'b1;
                state_d = ST_EMPTY;
            end else if (complete) begin
                pop_n   = grp_len;
                state_d = ST_FULL;
                ir_d    = e0;
                ir1_d   = p1 ? e1 : NOP_IR;
                ir2_d   = p2 ? e2 : NOP_IR;
                ir3_d   = p3 ? e3 : NOP_IR;
                npfx_d  = n;
            end else begin
                state_d = ST_EMPTY;
            end
        end
    end

    always_comb begin
        if (flush_i) begin
            wptr_d  = 3'd0;
            rptr_d  = 3'd0;
            count_d = 4'd0;
        end else begin
            wptr_d  = wptr_q + {2'b00, push};
            rptr_d  = rptr_q + pop_n[2:0];
            count_d = count_q + {3'b000, push} - pop_n;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wptr_q] <= in_ir_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= 3'd0;
            rptr_q  <= 3'd0;
            count_q <= 4'd0;
            state_q <= ST_EMPTY;
            ir_q    <= NOP_IR;
            ir1_q   <= NOP_IR;
            ir2_q   <= NOP_IR;
            ir3_q   <= NOP_IR;
            npfx_q  <= 2'd0;
            err_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            state_q <= state_d;
            ir_q    <= ir_d;
            ir1_q   <= ir1_d;
            ir2_q   <= ir2_d;
            ir3_q   <= ir3_d;
            npfx_q  <= npfx_d;
            err_q   <= err_d;
        end
    end

    assign out_valid_o  = (state_q == ST_FULL);
    assign out_ir_o     = ir_q;
    assign out_ir1_o    = ir1_q;
    assign out_ir2_o    = ir2_q;
    assign out_ir3_o    = ir3_q;
    assign out_npfx_o   = npfx_q;
    assign err_orphan_o = err_q;
    assign count_o      = count_q;
endmodule

// File: tb/tb_bw_decode_sequencer.sv
module tb_bw_decode_sequencer;
    localparam logic [39:0] NOP = 40'h0000000013;

    logic        rst_i, clk_i, flush_i, drain_i, in_valid_i, in_ready_o;
    logic [39:0] in_ir_i, out_ir_o, out_ir1_o, out_ir2_o, out_ir3_o;
    logic        out_valid_o, out_ready_i, err_orphan_o;
    logic [1:0]  out_npfx_o;
    logic [3:0]  count_o;

    int checks = 0;
    int failures = 0;

    bw_decode_sequencer #(
        .IW(40), .OPW(7), .CON1_OP(7'h0B), .CON2_OP(7'h2B), .CON3_OP(7'h5B),
        .NOP_IR(NOP), .DEPTH(8)
    ) dut (
        .rst_i(rst_i), .clk_i(clk_i), .flush_i(flush_i), .drain_i(drain_i),
        .in_valid_i(in_valid_i), .in_ir_i(in_ir_i), .in_ready_o(in_ready_o),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_ir_o(out_ir_o), .out_ir1_o(out_ir1_o), .out_ir2_o(out_ir2_o),
        .out_ir3_o(out_ir3_o), .out_npfx_o(out_npfx_o),
        .err_orphan_o(err_orphan_o), .count_o(count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [39:0] mk(input logic [32:0] hi, input logic [6:0] op);
        return {hi, op};
    endfunction

    logic [39:0] ADD, ADD2, LDO, ADDI, CON1, CON2, CON3;

    function automatic logic [39:0] seqi(input int k);
        return mk(33'h1000 + 33'(k), 7'h33);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_grp(input string tag, input logic [39:0] b, input logic [39:0] s1,
                           input logic [39:0] s2, input logic [39:0] s3, input logic [1:0] np);
        chk({tag, ".valid"}, 64'(out_valid_o), 64'd1);
        chk({tag, ".ir"},    64'(out_ir_o),  64'(b));
        chk({tag, ".ir1"},   64'(out_ir1_o), 64'(s1));
        chk({tag, ".ir2"},   64'(out_ir2_o), 64'(s2));
        chk({tag, ".ir3"},   64'(out_ir3_o), 64'(s3));
        chk({tag, ".npfx"},  64'(out_npfx_o), 64'(np));
    endtask

    task automatic push(input logic [39:0] ir);
        in_valid_i = 1'b1;
        in_ir_i    = ir;
        step();
    endtask

    initial begin
        ADD  = mk(33'h1, 7'h33);
        ADD2 = mk(33'h2, 7'h33);
        LDO  = mk(33'h3, 7'h03);
        ADDI = mk(33'h5, 7'h13);
        CON1 = mk(33'h11, 7'h0B);
        CON2 = mk(33'h12, 7'h2B);
        CON3 = mk(33'h13, 7'h5B);

        rst_i = 1'b1; flush_i = 1'b0; drain_i = 1'b0; in_valid_i = 1'b0;
        in_ir_i = '0; out_ready_i = 1'b1;
        #3;
        chk("rst.count", 64'(count_o), 64'd0);
        chk("rst.valid", 64'(out_valid_o), 64'd0);
        chk("rst.err",   64'(err_orphan_o), 64'd0);
        chk("rst.npfx",  64'(out_npfx_o), 64'd0);
        chk("rst.ir",    64'(out_ir_o), 64'(NOP));
        chk("rst.ir3",   64'(out_ir3_o), 64'(NOP));
        step();
        rst_i = 1'b0;
        chk("rst.in_ready", 64'(in_ready_o), 64'd1);

        // Two bases: first group waits for the second entry, then appears next cycle.
        push(ADD);
        chk("t1.count1", 64'(count_o), 64'd1);
        chk("t1.wait1", 64'(out_valid_o), 64'd0);
        push(ADD2);
        chk("t1.wait2", 64'(out_valid_o), 64'd0);
        in_valid_i = 1'b0;
        step();
        chk_grp("t1.grp", ADD, NOP, NOP, NOP, 2'd0);
        chk("t1.count", 64'(count_o), 64'd1);
        step();
        chk("t1.lone_wait", 64'(out_valid_o), 64'd0);
        drain_i = 1'b1;
        step();
        chk("t1.drain_ir", 64'(out_ir_o), 64'(ADD2));
        chk("t1.drain_cnt", 64'(count_o), 64'd0);
        drain_i = 1'b0;
        step();
        chk("t1.empty", 64'(out_valid_o), 64'd0);

        // Three postfixes: loaded as soon as CON3 is queued, while ADD is pushed.
        push(LDO); push(CON1); push(CON2); push(CON3);
        chk("t2.count4", 64'(count_o), 64'd4);
        chk("t2.notyet", 64'(out_valid_o), 64'd0);
        push(ADD);
        chk_grp("t2.grp", LDO, CON1, CON2, CON3, 2'd3);
        chk("t2.count", 64'(count_o), 64'd1);
        in_valid_i = 1'b0; drain_i = 1'b1;
        step();
        chk("t2.next", 64'(out_ir_o), 64'(ADD));
        drain_i = 1'b0;
        step();

        // Drain closes a partial group.
        push(ADDI); push(CON1);
        chk("t3.wait", 64'(out_valid_o), 64'd0);
        in_valid_i = 1'b0; drain_i = 1'b1;
        step();
        chk_grp("t3.grp", ADDI, CON1, NOP, NOP, 2'd1);
        drain_i = 1'b0;
        step();

        // Orphan postfix as the very first entry after reset.
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        push(CON1);
        chk("t4.err0", 64'(err_orphan_o), 64'd0);
        push(ADD);
        chk("t4.err", 64'(err_orphan_o), 64'd1);
        chk("t4.count", 64'(count_o), 64'd1);
        chk("t4.novalid", 64'(out_valid_o), 64'd0);
        push(ADD);
        chk("t4.errclr", 64'(err_orphan_o), 64'd0);
        in_valid_i = 1'b0;
        step();
        chk_grp("t4.grp", ADD, NOP, NOP, NOP, 2'd0);
        drain_i = 1'b1;
        step(); step();
        drain_i = 1'b0;
        chk("t4.clean", 64'(count_o), 64'd0);

        // Fill to 8 behind a stalled output, then stream with pointer wrap.
        out_ready_i = 1'b0;
        for (int k = 0; k < 9; k++) push(seqi(k));
        chk("t5.full", 64'(count_o), 64'd8);
        chk("t5.rdy0", 64'(in_ready_o), 64'd0);
        chk("t5.head", 64'(out_ir_o), 64'(seqi(0)));
        push(seqi(9));
        chk("t5.blocked", 64'(count_o), 64'd8);
        out_ready_i = 1'b1;
        step();
        chk("t5.pop1", 64'(out_ir_o), 64'(seqi(1)));
        chk("t5.cnt7", 64'(count_o), 64'd7);
        for (int k = 2; k <= 13; k++) begin
            in_ir_i = seqi(k + 7);
            step();
            chk($sformatf("t5.seq%0d", k), 64'(out_ir_o), 64'(seqi(k)));
            chk($sformatf("t5.cnt%0d", k), 64'(count_o), 64'd7);
        end
        in_valid_i = 1'b0; drain_i = 1'b1;
        for (int k = 0; k < 8; k++) step();
        drain_i = 1'b0;
        chk("t5.drained", 64'(count_o), 64'd0);
        chk("t5.empty", 64'(out_valid_o), 64'd0);

        // Flush while FULL with 5 queued and an offer pending.
        out_ready_i = 1'b0;
        for (int k = 0; k < 6; k++) push(seqi(40 + k));
        chk("t6.cnt5", 64'(count_o), 64'd5);
        chk("t6.full", 64'(out_valid_o), 64'd1);
        flush_i = 1'b1;
        in_ir_i = seqi(50);
        #1;
        chk("t6.rdy_fl", 64'(in_ready_o), 64'd0);
        step();
        chk("t6.cnt0", 64'(count_o), 64'd0);
        chk("t6.valid0", 64'(out_valid_o), 64'd0);
        chk("t6.err0", 64'(err_orphan_o), 64'd0);
        flush_i = 1'b0; in_valid_i = 1'b0;
        step();
        chk("t6.notq", 64'(count_o), 64'd0);

        // Same scenario with reset instead of flush.
        for (int k = 0; k < 6; k++) push(seqi(60 + k));
        chk("t7.cnt5", 64'(count_o), 64'd5);
        rst_i = 1'b1;
        #1;
        chk("t7.cnt0", 64'(count_o), 64'd0);
        chk("t7.valid0", 64'(out_valid_o), 64'd0);
        chk("t7.ir", 64'(out_ir_o), 64'(NOP));
        chk("t7.err0", 64'(err_orphan_o), 64'd0);
        step();
        rst_i = 1'b0;
        push(ADD);
        chk("t7.firstpush", 64'(count_o), 64'd1);
        in_valid_i = 1'b0; drain_i = 1'b1; out_ready_i = 1'b1;
        step();
        drain_i = 1'b0;
        step();

        // Fourth postfix after a full group becomes an orphan.
        push(LDO); push(CON1); push(CON2); push(CON3);
        push(CON1);
        chk_grp("t8.grp", LDO, CON1, CON2, CON3, 2'd3);
        chk("t8.cnt", 64'(count_o), 64'd1);
        push(ADD);
        chk("t8.err", 64'(err_orphan_o), 64'd1);
        chk("t8.cnt2", 64'(count_o), 64'd1);
        chk("t8.novalid", 64'(out_valid_o), 64'd0);
        in_valid_i = 1'b0; drain_i = 1'b1;
        step();
        chk("t8.add", 64'(out_ir_o), 64'(ADD));
        chk("t8.errclr", 64'(err_orphan_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
